// File: rtl/seg7_letter_decoder.sv
// seg7_letter_decoder: synchronizes a strobed 7-segment pattern, decodes it to a letter code and tracks the SEnOLGULGOnUL sequence.
// Optional strobe debounce filter enabled by defining SEG7_LETTER_DECODER_DEBOUNCE_EN.
module seg7_letter_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       seg_stb,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [3:0] sym_code,
  output logic       sym_err,
  output logic       match,
  output logic [3:0] seq_pos,
  output logic       ovf
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  localparam logic [3:0] SYM_S = 4'd0;
  localparam logic [3:0] SYM_UNK = 4'hF;
  // Expected sequence, element i in nibble i: S,E,n,O,L,G,U,L,G,O,n,U,L
  localparam logic [51:0] EXP_SEQ = 52'h4623546543210;
  logic       stb_s1_q, stb_s1_d, stb_s2_q, stb_s2_d;
  logic [6:0] seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_e_q, seg_e_d;
  logic       edge_q, edge_d, rise;
  logic [0:0] state_q, state_d;
  logic [3:0] code_q, code_d, pos_q, pos_d, dec, exp_code;
  logic       err_q, err_d, match_q, match_d, ovf_q, ovf_d;
  logic       load, hit, last;
`ifdef SEG7_LETTER_DECODER_DEBOUNCE_EN
  logic       filt_q, filt_d;
  logic [1:0] cnt_q, cnt_d;
  // Filter flips only on the 4th consecutive sample disagreeing with it
  always_comb begin
    cnt_d  = (stb_s2_q == filt_q) ? 2'd0 : cnt_q + 2'd1;
    filt_d = (stb_s2_q != filt_q && cnt_q == 2'd3) ? stb_s2_q : filt_q;
  end
  assign rise = filt_d & ~filt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  logic prev_q, prev_d;
  assign prev_d = stb_s2_q;
  assign rise   = stb_s2_q & ~prev_q;
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end
`endif
  always_comb begin
    dec = (seg_e_q == 7'b1011011) ? 4'd0 :
          (seg_e_q == 7'b1001111) ? 4'd1 :
          (seg_e_q == 7'b0010101) ? 4'd2 :
          (seg_e_q == 7'b1111110) ? 4'd3 :
          (seg_e_q == 7'b0001110) ? 4'd4 :
          (seg_e_q == 7'b1011111) ? 4'd5 :
          (seg_e_q == 7'b0111110) ? 4'd6 : SYM_UNK;
  end
  always_comb begin
    stb_s1_d = seg_stb;
    stb_s2_d = stb_s1_q;
    seg_s1_d = seg_in;
    seg_s2_d = seg_s1_q;
    edge_d   = rise;
    seg_e_d  = seg_s2_q;
    load     = edge_q && (state_q == EMPTY || sym_ready);
    exp_code = EXP_SEQ[{pos_q, 2'b00} +: 4];
    hit      = dec == exp_code;
    last     = pos_q == 4'd12;
    state_d  = load ? FULL : (state_q == FULL && sym_ready) ? EMPTY : state_q;
    code_d   = load ? dec : code_q;
    err_d    = load ? dec == SYM_UNK : err_q;
    pos_d    = !load ? pos_q : hit ? (last ? 4'd0 : pos_q + 4'd1) : (dec == SYM_S ? 4'd1 : 4'd0);
    match_d  = load && hit && last;
    ovf_d    = ovf_q | (edge_q && state_q == FULL && !sym_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_s1_q <= 1'b0;
      stb_s2_q <= 1'b0;
      seg_s1_q <= 7'd0;
      seg_s2_q <= 7'd0;
      edge_q   <= 1'b0;
      seg_e_q  <= 7'd0;
      state_q  <= EMPTY;
      code_q   <= 4'd0;
      err_q    <= 1'b0;
      pos_q    <= 4'd0;
      match_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      stb_s1_q <= stb_s1_d;
      stb_s2_q <= stb_s2_d;
      seg_s1_q <= seg_s1_d;
      seg_s2_q <= seg_s2_d;
      edge_q   <= edge_d;
      seg_e_q  <= seg_e_d;
      state_q  <= state_d;
      code_q   <= code_d;
      err_q    <= err_d;
      pos_q    <= pos_d;
      match_q  <= match_d;
      ovf_q    <= ovf_d;
    end
  end
  assign sym_valid = state_q == FULL;
  assign sym_code  = code_q;
  assign sym_err   = err_q;
  assign match     = match_q;
  assign seq_pos   = pos_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_seg7_letter_decoder.sv
// tb_seg7_letter_decoder: table-driven and randomized checks of seg7_letter_decoder against a rule-level model.
module tb_seg7_letter_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = 7'd0;
  logic       seg_stb = 1'b0;
  logic       sym_valid, sym_ready = 1'b1;
  logic [3:0] sym_code, seq_pos;
  logic       sym_err, match, ovf;
  int total = 0, bad = 0, mcnt = 0;
`ifdef SEG7_LETTER_DECODER_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 4;
`endif
  seg7_letter_decoder dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .seg_stb(seg_stb),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_code(sym_code),
    .sym_err(sym_err), .match(match), .seq_pos(seq_pos), .ovf(ovf)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (match) mcnt++;
  typedef struct { logic [6:0] seg; logic [3:0] code; logic err; } vec_t;
  vec_t tbl[10];
  logic [6:0] pat[7] = '{7'b1011011, 7'b1001111, 7'b0010101, 7'b1111110, 7'b0001110, 7'b1011111, 7'b0111110};
  int seq[13] = '{0, 1, 2, 3, 4, 5, 6, 4, 5, 3, 2, 6, 4};
  int mpos = 0;
  logic mmatch;
  logic g_got, g_err, g_match;
  logic [3:0] g_code, g_pos;
  int g_lat, g_nv;
  function automatic logic [3:0] ref_code(input logic [6:0] p);
    for (int i = 0; i < 7; i++) if (pat[i] == p) return 4'(i);
    return 4'hF;
  endfunction
  task automatic model(input logic [3:0] c);
    mmatch = 1'b0;
    if (int'(c) == seq[mpos]) begin
      if (mpos == 12) begin mpos = 0; mmatch = 1'b1; end
      else mpos++;
    end else mpos = (c == 4'd0) ? 1 : 0;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [6:0] p, input int len);
    g_got = 1'b0; g_lat = 0; g_nv = 0;
    @(negedge clk);
    seg_in = p;
    seg_stb = 1'b1;
    for (int c = 1; c <= len + 12; c++) begin
      @(negedge clk);
      if (c == len) seg_stb = 1'b0;
      if (sym_valid) g_nv++;
      if (sym_valid && !g_got) begin
        g_got = 1'b1; g_lat = c; g_code = sym_code; g_err = sym_err; g_match = match; g_pos = seq_pos;
      end
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; seg_stb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mpos = 0;
  endtask
  task automatic send_chk(input string nm, input logic [6:0] p, input int len);
    logic [3:0] c;
    c = ref_code(p);
    send(p, len);
    model(c);
    chk({nm, "_got"}, g_got, 1'b1);
    chk({nm, "_code"}, g_code, c);
    chk({nm, "_err"}, g_err, c == 4'hF);
    chk({nm, "_pos"}, g_pos, mpos);
    chk({nm, "_match"}, g_match, mmatch);
  endtask
  initial begin
    int m0, nrise;
    logic pv;
    tbl[0] = '{7'b1011011, 4'd0, 1'b0};
    tbl[1] = '{7'b1001111, 4'd1, 1'b0};
    tbl[2] = '{7'b0010101, 4'd2, 1'b0};
    tbl[3] = '{7'b1111110, 4'd3, 1'b0};
    tbl[4] = '{7'b0001110, 4'd4, 1'b0};
    tbl[5] = '{7'b1011111, 4'd5, 1'b0};
    tbl[6] = '{7'b0111110, 4'd6, 1'b0};
    tbl[7] = '{7'b0000001, 4'hF, 1'b1};
    tbl[8] = '{7'b1111111, 4'hF, 1'b1};
    tbl[9] = '{7'b1011010, 4'hF, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_outs", {sym_valid, sym_code, sym_err, match, seq_pos, ovf}, 12'd0);
    rst = 1'b0;
    mpos = 0;
    // single S: latency, one-cycle valid, decode, tracker
    send(7'b1011011, 5);
    model(4'd0);
    chk("first_lat", g_lat, LAT);
    chk("first_nv", g_nv, 1);
    chk("first_code", g_code, 4'd0);
    chk("first_err", g_err, 1'b0);
    chk("first_pos", g_pos, 4'd1);
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].seg, 5);
      model(tbl[i].code);
      chk("tbl_code", g_code, tbl[i].code);
      chk("tbl_err", g_err, tbl[i].err);
      chk("tbl_pos", g_pos, mpos);
      chk("tbl_nv", g_nv, 1);
    end
    // full sequence
    do_reset();
    m0 = mcnt;
    for (int i = 0; i < 13; i++) begin
      send(pat[seq[i]], 5);
      chk("seq_match", g_match, i == 12);
      chk("seq_pos", g_pos, (i == 12) ? 0 : i + 1);
    end
    chk("seq_mcnt", mcnt - m0, 1);
    chk("seq_pos_after", seq_pos, 4'd0);
    // unknown then S,E,S
    send_chk("unk", 7'b0000001, 5);
    chk("unk_pos", seq_pos, 4'd0);
    send_chk("ses_s", pat[0], 5);
    send_chk("ses_e", pat[1], 5);
    send_chk("ses_s2", pat[0], 5);
    chk("ses_pos", seq_pos, 4'd1);
    // overflow with downstream stalled
    do_reset();
    sym_ready = 1'b0;
    send(pat[0], 5);
    chk("ovf_first_code", g_code, 4'd0);
    chk("ovf_first_ovf", ovf, 1'b0);
    send(pat[1], 5);
    chk("ovf_hold_valid", sym_valid, 1'b1);
    chk("ovf_hold_code", sym_code, 4'd0);
    chk("ovf_hold_err", sym_err, 1'b0);
    chk("ovf_flag", ovf, 1'b1);
    chk("ovf_pos", seq_pos, 4'd1);
    sym_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovf_drain", sym_valid, 1'b0);
    chk("ovf_sticky", ovf, 1'b1);
    // reset mid-sequence with strobe held through release
    do_reset();
    for (int i = 0; i < 7; i++) begin
      sym_ready = (i < 6);
      send(pat[seq[i]], 5);
    end
    chk("mid_pos", seq_pos, 4'd7);
    chk("mid_valid", sym_valid, 1'b1);
    rst = 1'b1; seg_stb = 1'b1; seg_in = pat[0]; sym_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", {sym_valid, sym_code, sym_err, match, seq_pos, ovf}, 12'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nrise = 0; pv = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 8) seg_stb = 1'b0;
      if (sym_valid && !pv) begin
        nrise++;
        chk("rel_code", sym_code, 4'd0);
        chk("rel_pos", seq_pos, 4'd1);
      end
      pv = sym_valid;
    end
    chk("rel_nsym", nrise, 1);
`ifdef SEG7_LETTER_DECODER_DEBOUNCE_EN
    // short glitch must be filtered, 6-cycle pulse must pass
    do_reset();
    send(pat[0], 2);
    chk("glitch_nv", g_nv, 0);
    send(pat[0], 6);
    chk("deb_lat", g_lat, 7);
    chk("deb_code", g_code, 4'd0);
`endif
    // randomized stream
    do_reset();
    m0 = mcnt;
    for (int k = 0; k < 40; k++) begin
      int r;
      logic [6:0] p;
      r = $urandom_range(0, 9);
      if (r < 7) p = pat[seq[mpos]];
      else if (r < 9) p = pat[$urandom_range(0, 6)];
      else p = 7'($urandom);
      send_chk("rnd", p, $urandom_range(5, 7));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
